// File: rtl/io_display_pkg.sv
// Shared definitions for the I/O display controller.
// Contents: the register address map, the CTRL reset value and writable-bit mask,
// the scan state type, and the hex-to-seven-segment encoder.
package io_display_pkg;

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_LED   = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_KEY   = 2'd3;

    // Enabled, no leading-zero suppress, no decimal points lit.
    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
    // Only enable, suppress and the dp mask are stored; every other bit reads as 0.
    localparam logic [31:0] CTRL_MASK  = 32'h0000_FF03;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_e;

    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp is always off here.
    function automatic logic [7:0] seg7(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: a two-flop synchronizer followed by a stability counter.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset
//   i_key           raw asynchronous button level
//   o_deb           debounced level
//   o_rise          high in the cycle whose clock edge takes o_deb from 0 to 1
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key,
    output logic o_deb,
    output logic o_rise
);

    logic        r_s1;
    logic        r_s2;
    logic        r_deb;
    logic [31:0] r_cnt;

    logic        w_diff;
    logic        w_done;

    // The counter only runs while the synced level disagrees with the accepted level.
    assign w_diff = (r_s2 != r_deb);
    assign w_done = w_diff && (r_cnt == DEBOUNCE_CYC - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_key;
            r_s2 <= r_s1;
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_done) begin
                r_deb <= r_s2;
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = w_done && r_s2;

endmodule

// File: rtl/io_display_ctrl.sv
// Memory-mapped controller for an 8-digit seven-segment display, 16 LEDs and a key.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   io_we, io_re      one-cycle write / read strobes
//   io_addr           0 VALUE, 1 LED, 2 CTRL, 3 KEY
//   io_wdata          write data
//   io_rdata          registered read data, held between reads
//   key               raw button input, active-high
//   digit             one-hot active-low digit enables (bit 0 = rightmost)
//   fnd               active-low segments {dp,g,f,e,d,c,b,a}
//   LED               LED register contents
module io_display_ctrl
    import io_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_we,
    input  logic        io_re,
    input  logic [1:0]  io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        key,
    output logic [7:0]  digit,
    output logic [7:0]  fnd,
    output logic [15:0] LED
);

    logic [31:0] r_value;
    logic [15:0] r_led;
    logic [31:0] r_ctrl;
    logic [31:0] r_rdata;
    logic [31:0] r_shadow;
    logic        r_sticky;
    scan_state_e r_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_digit;
    logic [7:0]  r_fnd;

    scan_state_e w_state_d;
    logic [31:0] w_cnt_d;
    logic [2:0]  w_idx_d;
    logic        w_snap;
    logic [7:0]  w_digit_d;
    logic [7:0]  w_fnd_d;
    logic [3:0]  w_nib;
    logic [31:0] w_upper;
    logic [7:0]  w_dp_mask;
    logic [31:0] w_rdata_d;
    logic        w_deb;
    logic        w_rise;
    logic        w_key_rd;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .i_clk   (clk),
        .i_reset (reset),
        .i_key   (key),
        .o_deb   (w_deb),
        .o_rise  (w_rise)
    );

    assign w_key_rd  = io_re && (io_addr == ADDR_KEY);
    assign w_dp_mask = r_ctrl[15:8];

    always_comb begin
        w_rdata_d = r_rdata;
        if (io_re) begin
            case (io_addr)
                ADDR_VALUE: w_rdata_d = r_value;
                ADDR_LED:   w_rdata_d = {16'd0, r_led};
                ADDR_CTRL:  w_rdata_d = r_ctrl;
                default:    w_rdata_d = {30'd0, r_sticky, w_deb};
            endcase
        end
    end

    // Scan next-state; digit/fnd are computed from the next state so they register with it.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_snap    = 1'b0;
        if (!r_ctrl[0]) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_idx_d   = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_d = StBlank;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_snap    = 1'b1;
                end
                StBlank: begin
                    if (r_cnt == BLANK_CYC - 1) begin
                        w_state_d = StShow;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 32'd1;
                    end
                end
                StShow: begin
                    if (r_cnt == SCAN_DIV - BLANK_CYC - 1) begin
                        w_state_d = StBlank;
                        w_cnt_d   = '0;
                        w_idx_d   = r_idx + 3'd1;
                        // Wrapping back to digit 0 starts a new frame: refresh the snapshot.
                        w_snap    = (r_idx == 3'd7);
                    end else begin
                        w_cnt_d = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end
            endcase
        end

        w_nib     = r_shadow[{w_idx_d, 2'b00} +: 4];
        w_upper   = r_shadow >> {w_idx_d, 2'b00};
        w_digit_d = 8'hFF;
        w_fnd_d   = 8'hFF;
        if (w_state_d == StShow) begin
            w_digit_d = ~(8'd1 << w_idx_d);
            // Leading-zero suppress blanks the segments only; the digit enable stays on.
            if (!(r_ctrl[1] && (w_idx_d != 3'd0) && (w_upper == 32'd0))) begin
                w_fnd_d = seg7(w_nib) & ~{w_dp_mask[w_idx_d], 7'd0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value  <= '0;
            r_led    <= '0;
            r_ctrl   <= CTRL_RESET;
            r_rdata  <= '0;
            r_shadow <= '0;
            r_sticky <= 1'b0;
            r_state  <= StBlank;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_digit  <= 8'hFF;
            r_fnd    <= 8'hFF;
        end else begin
            if (io_we) begin
                case (io_addr)
                    ADDR_VALUE: r_value <= io_wdata;
                    ADDR_LED:   r_led   <= io_wdata[15:0];
                    ADDR_CTRL:  r_ctrl  <= io_wdata & CTRL_MASK;
                    default:    ;
                endcase
            end
            r_rdata <= w_rdata_d;
            // A new press beats a clearing read in the same cycle.
            if (w_rise) begin
                r_sticky <= 1'b1;
            end else if (w_key_rd) begin
                r_sticky <= 1'b0;
            end
            if (w_snap) begin
                r_shadow <= r_value;
            end
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_digit <= w_digit_d;
            r_fnd   <= w_fnd_d;
        end
    end

    assign io_rdata = r_rdata;
    assign digit    = r_digit;
    assign fnd      = r_fnd;
    assign LED      = r_led;

endmodule
